// File: rtl/cpu_defs.sv
// Shared definitions for the cpu controller, the ALU control logic and benches:
// opcode constants, special instruction encodings, controller states and
// small opcode-classification helpers.
package cpu_defs;

  localparam logic [3:0] OP_CODE_AND  = 4'b0001;
  localparam logic [3:0] OP_CODE_OR   = 4'b0010;
  localparam logic [3:0] OP_CODE_XOR  = 4'b0011;
  localparam logic [3:0] OP_CODE_LSH  = 4'b0100;
  localparam logic [3:0] OP_CODE_ADD  = 4'b0101;
  localparam logic [3:0] OP_CODE_ADDU = 4'b0110;
  localparam logic [3:0] OP_CODE_ADDC = 4'b0111;
  localparam logic [3:0] OP_CODE_SUB  = 4'b1001;
  localparam logic [3:0] OP_CODE_SUBC = 4'b1010;
  localparam logic [3:0] OP_CODE_CMP  = 4'b1011;

  localparam logic [3:0] OP_MAJOR_REG   = 4'b0000;
  localparam logic [3:0] OP_MAJOR_SHIFT = 4'b1000;

  localparam logic [15:0] INSTR_HALT = 16'hFFFF;
  localparam logic [15:0] INSTR_NOP  = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_HALT
  } ctrl_state_e;

  // How an operation touches the register file and the flags.
  typedef enum logic [1:0] {
    CLS_NONE,   // not an ALU operation
    CLS_ARITH,  // writes result and flags
    CLS_LOGIC,  // writes result only
    CLS_CMP     // writes flags only
  } op_class_e;

  function automatic op_class_e op_class(input logic [3:0] op);
    case (op)
      OP_CODE_ADD, OP_CODE_ADDU, OP_CODE_ADDC,
      OP_CODE_SUB, OP_CODE_SUBC:              op_class = CLS_ARITH;
      OP_CODE_AND, OP_CODE_OR, OP_CODE_XOR,
      OP_CODE_LSH:                            op_class = CLS_LOGIC;
      OP_CODE_CMP:                            op_class = CLS_CMP;
      default:                                op_class = CLS_NONE;
    endcase
  endfunction

  // Majors that carry an 8-bit immediate; there is no immediate shift.
  function automatic logic is_imm_major(input logic [3:0] major);
    is_imm_major = (op_class(major) != CLS_NONE) && (major != OP_CODE_LSH);
  endfunction

  // Signed arithmetic and compare sign-extend imm8; the rest zero-extend.
  function automatic logic imm_is_signed(input logic [3:0] major);
    case (major)
      OP_CODE_ADD, OP_CODE_ADDC, OP_CODE_SUB,
      OP_CODE_SUBC, OP_CODE_CMP: imm_is_signed = 1'b1;
      default:                   imm_is_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder: maps one 16-bit instruction word
// to the ALU opcode, register addresses, extended immediate and strobes.
module instr_decode
  import cpu_defs::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 3
) (
  input  logic [15:0]              instr,
  output logic [3:0]               opcode,
  output logic [REG_ADDR_BITS-1:0] addr_a,
  output logic [REG_ADDR_BITS-1:0] addr_b,
  output logic [REG_WIDTH-1:0]     imm,
  output logic                     use_imm,
  output logic                     reg_we,
  output logic                     flags_we,
  output logic                     is_halt,
  output logic                     is_illegal
);

  logic [3:0] major;
  logic [3:0] opext;
  op_class_e  cls;

  assign major = instr[15:12];
  assign opext = instr[7:4];

  // Classify the word, then fill in fields only for a recognised operation.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // leaves a value unassigned, which would otherwise infer a latch.
    opcode     = '0;
    addr_a     = '0;
    addr_b     = '0;
    imm        = '0;
    use_imm    = 1'b0;
    cls        = CLS_NONE;
    is_halt    = (instr == INSTR_HALT);

    if (major == OP_MAJOR_REG && instr != INSTR_NOP) begin
      cls    = op_class(opext);
      opcode = opext;
    end else if (major == OP_MAJOR_SHIFT && opext == OP_CODE_LSH) begin
      cls    = CLS_LOGIC;
      opcode = OP_CODE_LSH;
    end else if (is_imm_major(major)) begin
      cls     = op_class(major);
      opcode  = major;
      use_imm = 1'b1;
      imm     = imm_is_signed(major) ? {{(REG_WIDTH-8){instr[7]}}, instr[7:0]}
                                     : {{(REG_WIDTH-8){1'b0}}, instr[7:0]};
    end

    if (cls != CLS_NONE) begin
      addr_a = instr[8 +: REG_ADDR_BITS];
      addr_b = use_imm ? '0 : instr[0 +: REG_ADDR_BITS];
    end else begin
      // Unrecognised register-form extensions must not leak an opcode.
      opcode = '0;
    end

    reg_we     = (cls == CLS_ARITH) || (cls == CLS_LOGIC);
    flags_we   = (cls == CLS_ARITH) || (cls == CLS_CMP);
    is_illegal = (cls == CLS_NONE) && !is_halt && (instr != INSTR_NOP);
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute controller for the cpu datapath. Holds the
// program counter, the instruction register, the FSM and the registered
// control outputs presented to the register file and ALU.
module cpu_controller
  import cpu_defs::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int REG_ADDR_BITS = 3,
  parameter int PC_WIDTH      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              instrData,
  output logic [PC_WIDTH-1:0]      instrAddr,
  output logic                     instrReadEnable,
  output logic [3:0]               aluOpCode,
  output logic [REG_ADDR_BITS-1:0] regAddressA,
  output logic [REG_ADDR_BITS-1:0] regAddressB,
  output logic [REG_WIDTH-1:0]     immediate,
  output logic                     useImm,
  output logic                     regWriteEnable,
  output logic                     flagsWriteEnable,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal
);

  ctrl_state_e             state;
  ctrl_state_e             state_next;
  logic [PC_WIDTH-1:0]     pc;
  logic [15:0]             ir;

  logic [3:0]              dec_opcode;
  logic [REG_ADDR_BITS-1:0] dec_addr_a;
  logic [REG_ADDR_BITS-1:0] dec_addr_b;
  logic [REG_WIDTH-1:0]    dec_imm;
  logic                    dec_use_imm;
  logic                    dec_reg_we;
  logic                    dec_flags_we;
  logic                    dec_is_halt;
  logic                    dec_is_illegal;

  // The memory word is decoded while it is on instrData during DECODE, so the
  // registered fields are already valid at the first edge of EXEC.
  instr_decode #(
    .REG_WIDTH     (REG_WIDTH),
    .REG_ADDR_BITS (REG_ADDR_BITS)
  ) u_decode (
    .instr      (instrData),
    .opcode     (dec_opcode),
    .addr_a     (dec_addr_a),
    .addr_b     (dec_addr_b),
    .imm        (dec_imm),
    .use_imm    (dec_use_imm),
    .reg_we     (dec_reg_we),
    .flags_we   (dec_flags_we),
    .is_halt    (dec_is_halt),
    .is_illegal (dec_is_illegal)
  );

  assign instrAddr = pc;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next      = state;
    instrReadEnable = 1'b0;
    busy            = 1'b0;
    halted          = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        halted = (state == ST_HALT);
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        instrReadEnable = 1'b1;
        busy            = 1'b1;
        state_next      = ST_DECODE;
      end
      ST_DECODE: begin
        busy       = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        busy       = 1'b1;
        state_next = (ir == INSTR_HALT) ? ST_HALT : ST_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Program counter advances once per executed instruction; the instruction
  // register captures the memory word at the end of DECODE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (state == ST_DECODE) ir <= instrData;
      if (state == ST_EXEC)   pc <= pc + PC_WIDTH'(1);
    end
  end

  // Operand registers load at the DECODE->EXEC edge and hold until the next
  // EXEC. A halt leaves the last operands in place while the controller waits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aluOpCode   <= '0;
      regAddressA <= '0;
      regAddressB <= '0;
      immediate   <= '0;
      useImm      <= 1'b0;
    end else if (state == ST_DECODE && !dec_is_halt) begin
      aluOpCode   <= dec_opcode;
      regAddressA <= dec_addr_a;
      regAddressB <= dec_addr_b;
      immediate   <= dec_imm;
      useImm      <= dec_use_imm;
    end
  end

  // Strobes are high only for the single EXEC cycle of each instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteEnable   <= 1'b0;
      flagsWriteEnable <= 1'b0;
      illegal          <= 1'b0;
    end else begin
      regWriteEnable   <= (state == ST_DECODE) && dec_reg_we;
      flagsWriteEnable <= (state == ST_DECODE) && dec_flags_we;
      illegal          <= (state == ST_DECODE) && dec_is_illegal;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller: runs a small program from a
// synchronous ROM model and checks every field against hand-computed values.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        start_small;
  logic [15:0] rom_data = 16'h0000;
  logic [15:0] rom [256];

  logic [7:0]  instrAddr;
  logic        instrReadEnable;
  logic [3:0]  aluOpCode;
  logic [2:0]  regAddressA;
  logic [2:0]  regAddressB;
  logic [15:0] immediate;
  logic        useImm;
  logic        regWriteEnable;
  logic        flagsWriteEnable;
  logic        busy;
  logic        halted;
  logic        illegal;

  logic [1:0]  s_addr;
  logic        s_re;
  logic [3:0]  s_op;
  logic [2:0]  s_a;
  logic [2:0]  s_b;
  logic [15:0] s_imm;
  logic        s_use_imm;
  logic        s_rwe;
  logic        s_fwe;
  logic        s_busy;
  logic        s_halted;
  logic        s_illegal;

  int vectors     = 0;
  int miscompares = 0;

  logic [3:0] held_op;
  bit         hold_valid = 1'b0;

  always #5 clk = ~clk;

  cpu_controller #(.REG_WIDTH(16), .REG_ADDR_BITS(3), .PC_WIDTH(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .instrData        (rom_data),
    .instrAddr        (instrAddr),
    .instrReadEnable  (instrReadEnable),
    .aluOpCode        (aluOpCode),
    .regAddressA      (regAddressA),
    .regAddressB      (regAddressB),
    .immediate        (immediate),
    .useImm           (useImm),
    .regWriteEnable   (regWriteEnable),
    .flagsWriteEnable (flagsWriteEnable),
    .busy             (busy),
    .halted           (halted),
    .illegal          (illegal)
  );

  // Narrow-PC instance fed only NOPs to exercise address wrap.
  cpu_controller #(.REG_WIDTH(16), .REG_ADDR_BITS(3), .PC_WIDTH(2)) dut_small (
    .clk              (clk),
    .reset            (reset),
    .start            (start_small),
    .instrData        (16'h0000),
    .instrAddr        (s_addr),
    .instrReadEnable  (s_re),
    .aluOpCode        (s_op),
    .regAddressA      (s_a),
    .regAddressB      (s_b),
    .immediate        (s_imm),
    .useImm           (s_use_imm),
    .regWriteEnable   (s_rwe),
    .flagsWriteEnable (s_fwe),
    .busy             (s_busy),
    .halted           (s_halted),
    .illegal          (s_illegal)
  );

  // Synchronous instruction memory: data one cycle after the read strobe.
  always @(posedge clk) if (instrReadEnable) rom_data <= rom[instrAddr];

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge after EXEC.
  task automatic run_instr(input string tag, input logic [7:0] addr, input bit check_fields,
                           input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [15:0] imm, input logic use_imm,
                           input logic rwe, input logic fwe, input logic ill);
    check({tag, "/addr"}, 64'(instrAddr), 64'(addr));
    check({tag, "/fetch"}, 64'({busy, halted, instrReadEnable, regWriteEnable, flagsWriteEnable, illegal}),
          64'(6'b101000));
    if (hold_valid) check({tag, "/hold_f"}, 64'(aluOpCode), 64'(held_op));
    @(negedge clk);
    check({tag, "/decode"}, 64'({busy, instrReadEnable, regWriteEnable, flagsWriteEnable, illegal}),
          64'(5'b10000));
    if (hold_valid) check({tag, "/hold_d"}, 64'(aluOpCode), 64'(held_op));
    @(negedge clk);
    check({tag, "/strobes"}, 64'({busy, regWriteEnable, flagsWriteEnable, illegal}),
          64'({1'b1, rwe, fwe, ill}));
    hold_valid = check_fields;
    if (check_fields) begin
      held_op = op;
      check({tag, "/op"},     64'(aluOpCode),   64'(op));
      check({tag, "/addr_a"}, 64'(regAddressA), 64'(a));
      check({tag, "/use_imm"}, 64'(useImm),     64'(use_imm));
      if (use_imm) check({tag, "/imm"},    64'(immediate),   64'(imm));
      else         check({tag, "/addr_b"}, 64'(regAddressB), 64'(b));
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [1:0] small_exp [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0]  = 16'h0151;  // ADD R1,R1
    rom[1]  = 16'h52FF;  // ADDI R2,-1
    rom[2]  = 16'h12FF;  // ANDI R2,0xFF
    rom[3]  = 16'h0BB2;  // CMP R3,R2
    rom[4]  = 16'h0000;  // NOP
    rom[5]  = 16'hE123;  // illegal
    rom[6]  = 16'hFFFF;  // HALT
    rom[7]  = 16'h8342;  // LSH R3,R2
    rom[8]  = 16'h3F80;  // XORI R7,0x80
    rom[9]  = 16'hB480;  // CMPI R4,-128
    rom[10] = 16'h9401;  // SUBI R4,1
    rom[11] = 16'hFFFF;  // HALT
    rom[12] = 16'h5101;  // ADDI R1,1 (aborted by reset)

    reset = 1'b0;
    start = 1'b0;
    start_small = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({instrAddr, instrReadEnable, aluOpCode, regAddressA, regAddressB, immediate,
                                useImm, regWriteEnable, flagsWriteEnable, busy, halted, illegal}), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle", 64'({busy, halted, instrReadEnable}), 64'd0);

    pulse_start();
    run_instr("add_r",  8'd0, 1'b1, 4'b0101, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);
    run_instr("addi",   8'd1, 1'b1, 4'b0101, 3'd2, 3'd0, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr("andi",   8'd2, 1'b1, 4'b0001, 3'd2, 3'd0, 16'h00FF, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr("cmp_r",  8'd3, 1'b1, 4'b1011, 3'd3, 3'd2, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    run_instr("nop",    8'd4, 1'b0, 4'h0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_instr("illeg",  8'd5, 1'b0, 4'h0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("illegal_one_cycle", 64'(illegal), 64'd0);
    run_instr("halt",   8'd6, 1'b0, 4'h0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    check("halt_pc", 64'(instrAddr), 64'd7);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_idle%0d", i),
            64'({instrReadEnable, regWriteEnable, flagsWriteEnable, illegal, busy, halted}), 64'(6'b000001));
      @(negedge clk);
    end

    pulse_start();
    run_instr("lsh",    8'd7,  1'b1, 4'b0100, 3'd3, 3'd2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    run_instr("xori",   8'd8,  1'b1, 4'b0011, 3'd7, 3'd0, 16'h0080, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr("cmpi",   8'd9,  1'b1, 4'b1011, 3'd4, 3'd0, 16'hFF80, 1'b1, 1'b0, 1'b1, 1'b0);
    run_instr("subi",   8'd10, 1'b1, 4'b1001, 3'd4, 3'd0, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
    run_instr("halt2",  8'd11, 1'b0, 4'h0, 3'd0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("halt2_state", 64'({busy, halted, instrAddr}), 64'({1'b0, 1'b1, 8'd12}));

    // Abort an instruction with reset while it is in DECODE.
    pulse_start();
    @(negedge clk);
    check("abort_in_decode", 64'({busy, instrReadEnable}), 64'(2'b10));
    reset = 1'b0;
    #1;
    check("abort_outputs", 64'({instrAddr, instrReadEnable, aluOpCode, regAddressA, regAddressB, immediate,
                                useImm, regWriteEnable, flagsWriteEnable, busy, halted, illegal}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("abort_quiet%0d", i), 64'({regWriteEnable, flagsWriteEnable, illegal, busy}), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("release_state", 64'({busy, halted, instrReadEnable, instrAddr}), 64'd0);
    hold_valid = 1'b0;
    pulse_start();
    run_instr("restart", 8'd0, 1'b1, 4'b0101, 3'd1, 3'd1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0);

    // Two-bit PC wraps silently from 3 back to 0.
    start_small = 1'b1;
    @(negedge clk);
    start_small = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wrap_addr%0d", i), 64'({s_re, s_addr}), 64'({1'b1, small_exp[i]}));
      repeat (2) @(negedge clk);
      check($sformatf("wrap_exec%0d", i), 64'({s_busy, s_rwe, s_fwe, s_illegal}), 64'(4'b1000));
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
